// File: rtl/conv_window_ctrl_if.sv
// Pixel-stream handshake, window handshake and status signals of the sliding-window controller.
// master = stream source/sink side, slave = the controller.
interface conv_window_ctrl_if;
   logic       start;
   logic       in_valid;
   logic       in_ready;
   logic       ce;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] win_row;
   logic [7:0] win_col;
   logic       frame_done;
   logic       busy;

   modport master (
      output start, in_valid, out_ready,
      input  in_ready, ce, out_valid, win_row, win_col, frame_done, busy
   );

   modport slave (
      input  start, in_valid, out_ready,
      output in_ready, ce, out_valid, win_row, win_col, frame_done, busy
   );
endinterface

// File: rtl/conv_window_ctrl.sv
// Sliding KxK window controller for an NxN raster frame: gates the line-buffer shift
// enable, tracks pixel coordinates and presents each complete window with its top-left corner.
//
// state | meaning
// IDLE  | waiting for start, stream ignored
// FILL  | accepting pixels, first window not yet complete
// RUN   | accepting pixels, windows being produced
// DONE  | last pixel taken, draining the final window
module conv_window_ctrl #(
   parameter int N = 9,
   parameter int K = 3
) (
   input logic               clk,
   input logic               rst,
   conv_window_ctrl_if.slave bus
);
   localparam logic [7:0] KM1 = 8'(K - 1);
   localparam logic [7:0] NM1 = 8'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] row_q, row_d;
   logic [7:0] col_q, col_d;
   logic [7:0] win_row_q, win_row_d;
   logic [7:0] win_col_q, win_col_d;
   logic       out_valid_q, out_valid_d;
   logic       frame_done_q, frame_done_d;

   logic in_ready;
   logic accept;
   logic consume;
   logic win_hit;
   logic fill_px;
   logic last_px;

   // A window held for a stalled consumer freezes the whole delay line.
   assign in_ready = ((state_q == FILL) || (state_q == RUN)) && !(out_valid_q && !bus.out_ready);
   assign accept   = bus.in_valid && in_ready;
   assign consume  = out_valid_q && bus.out_ready;
   assign win_hit  = accept && (row_q >= KM1) && (col_q >= KM1);
   assign fill_px  = (row_q == KM1) && (col_q == KM1);
   assign last_px  = (row_q == NM1) && (col_q == NM1);

   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      col_d        = col_q;
      frame_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = FILL;
               row_d   = 8'd0;
               col_d   = 8'd0;
            end
         end
         FILL: begin
            if (accept) begin
               if (last_px) begin
                  state_d = DONE;
               end else if (fill_px) begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (accept && last_px) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (!out_valid_q || consume) begin
               state_d      = IDLE;
               frame_done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (accept) begin
         if (col_q == NM1) begin
            col_d = 8'd0;
            row_d = row_q + 8'd1;
         end else begin
            col_d = col_q + 8'd1;
         end
      end
   end

   // A new window wins over a simultaneous consume so back-to-back windows stream at full rate.
   always_comb begin
      out_valid_d = out_valid_q;
      win_row_d   = win_row_q;
      win_col_d   = win_col_q;
      if (win_hit) begin
         out_valid_d = 1'b1;
         win_row_d   = row_q - KM1;
         win_col_d   = col_q - KM1;
      end else if (consume) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         row_q        <= 8'd0;
         col_q        <= 8'd0;
         win_row_q    <= 8'd0;
         win_col_q    <= 8'd0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         col_q        <= col_d;
         win_row_q    <= win_row_d;
         win_col_q    <= win_col_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.ce         = accept;
   assign bus.out_valid  = out_valid_q;
   assign bus.win_row    = win_row_q;
   assign bus.win_col    = win_col_q;
   assign bus.frame_done = frame_done_q;
   assign bus.busy       = (state_q != IDLE);
endmodule

// File: doc/conv_window_ctrl.md
CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

Interface
REQ-001 SHALL have parameter N, default 9, meaning image width and height in pixels (square frame, 3 <= N <= 255).
REQ-002 SHALL have parameter K, default 3, meaning kernel size (2 <= K <= N); the line-buffer delay-line depth is fixed by the instantiating datapath.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: frame start request, sampled only in IDLE.
REQ-006 SHALL have port in_valid, input, 1 bit: an upstream pixel is presented.
REQ-007 SHALL have port in_ready, output, 1 bit, combinational: the controller accepts a pixel this cycle.
REQ-008 SHALL have port ce, output, 1 bit, combinational: shift enable to the line-buffer shift registers; ce = in_valid & in_ready.
REQ-009 SHALL have port out_valid, output, 1 bit, registered: the window in the datapath is complete.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream consumes the window when out_valid & out_ready.
REQ-011 SHALL have port win_row, output, 8 bits, registered: top-left row of the valid window.
REQ-012 SHALL have port win_col, output, 8 bits, registered: top-left column of the valid window.
REQ-013 SHALL have port frame_done, output, 1 bit, registered: one-cycle end-of-frame pulse.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 SHALL implement four states: IDLE, FILL, RUN and DONE.
REQ-016 SHALL define accept as in_valid & in_ready; an accepted pixel is the one carrying coordinates (row, col), with internal counters row and col each 8 bits.
REQ-017 SHALL drive in_ready = (state is FILL or RUN) & !(out_valid & !out_ready); a window held for a stalled downstream blocks all shifting.
REQ-018 SHALL advance col on accept; when col = N-1, col wraps to 0 and row increments.
REQ-019 SHALL, on accept with row >= K-1 and col >= K-1, set out_valid on the next edge with win_row = row-(K-1) and win_col = col-(K-1).
REQ-020 SHALL clear out_valid when out_valid & out_ready and no new window is produced in the same cycle; a simultaneous consume and new window keeps out_valid at 1 and loads the new coordinates.
REQ-021 SHALL hold win_row and win_col stable while out_valid is high and out_ready is low.
REQ-022 SHALL not produce a window for column positions col < K-1, including across the row wrap.
REQ-023 SHALL, in IDLE with start high, clear row and col and go to FILL; start is ignored in every other state.
REQ-024 SHALL move from FILL to RUN on the accept of the pixel (K-1, K-1).
REQ-025 SHALL move from RUN to DONE on the accept of pixel (N-1, N-1).
REQ-026 SHALL, in DONE with in_ready = 0, leave DONE only when out_valid is low or out_valid & out_ready.
REQ-027 SHALL, on leaving DONE, go to IDLE and pulse frame_done high for exactly the one cycle in which the state is IDLE after that transition.
REQ-028 SHALL ignore in_valid in IDLE and DONE, keeping ce at 0 in those states.

Reset
REQ-029 SHALL, with rst high at a rising edge, set state to IDLE, row = col = 0, out_valid = 0, win_row = win_col = 0 and frame_done = 0, overriding any start, in_valid or out_ready.
REQ-030 SHALL, on rst asserted mid-frame, discard any pending window with no frame_done pulse; in_ready and ce are 0 in the cycle following reset.

Verification (N=4, K=3)
REQ-031 SHALL verify the continuous frame: start, then 16 pixels with out_ready=1 -> exactly 4 windows (0,0),(0,1),(1,0),(1,1), each 1 cycle after accepts 10, 11, 14, 15; frame_done pulses once; ce high for exactly 16 cycles.
REQ-032 SHALL verify backpressure: out_ready=0 while window (0,0) is valid -> in_ready=0, ce=0, win coordinates stable; releasing out_ready resumes with no pixel lost or duplicated.
REQ-033 SHALL verify the end-of-frame drain: out_ready=0 when pixel 15 is accepted -> state DONE, out_valid=1 held, frame_done deferred until the cycle after the consume.
REQ-034 SHALL verify row wrap: accepts 12 and 13 (col 0 and 1 of row 3) -> no out_valid.
REQ-035 SHALL verify reset mid-frame: rst after 12 accepts -> out_valid=0, busy=0, no frame_done; a fresh start then yields the full 4-window frame.
REQ-036 SHALL verify start is ignored while busy: start pulsed in RUN -> row and col unaffected and the window count stays 4.
